// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter
// ---------------------------------------------------------------------------
// Shares the single external CPU memory bus between the instruction-fetch
// master (master 0) and the data-memory master (master 1). One master owns
// the bus at a time, the owner's request fields are latched when it is
// granted, and a watchdog completes transfers that the slave never
// acknowledges.
//
// Parameters
//   PRIORITY : 0 = round-robin on contention, 1 = master 1 wins contention
//   TIMEOUT  : stalled granted cycles before forced completion, 0 = disabled
//
// Ports
//   i_clock                    system clock, rising edge
//   i_reset                    asynchronous reset, active low
//   i_mX_request/rw/address/wdata   master X request side (X = 0, 1)
//   o_mX_ready, o_mX_rdata     master X completion strobe and read data
//   o_bus_request/rw/address/wdata  request to the slave
//   i_bus_ready, i_bus_rdata   slave completion strobe and read data
//   o_timeout                  one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module cpu_bus_arbiter #(
    parameter int PRIORITY = 0,
    parameter int TIMEOUT  = 1023
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_m0_request,
    input  logic        i_m0_rw,
    input  logic [31:0] i_m0_address,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_request,
    input  logic        i_m1_rw,
    input  logic [31:0] i_m1_address,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_timeout
);

    // A disabled watchdog still needs a legal one-bit counter.
    localparam int COUNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The watchdog fires on the TIMEOUT-th stalled cycle, i.e. while the
    // counter still holds TIMEOUT-1 stalls from the cycles before.
    localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
        (TIMEOUT > 0) ? COUNT_WIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   owner;
    logic                   owner_next;
    logic                   last_served;
    logic                   last_served_next;
    logic [COUNT_WIDTH-1:0] stall_count;
    logic [COUNT_WIDTH-1:0] stall_count_next;
    logic                   lat_rw;
    logic                   lat_rw_next;
    logic [31:0]            lat_address;
    logic [31:0]            lat_address_next;
    logic [31:0]            lat_wdata;
    logic [31:0]            lat_wdata_next;

    logic                   granted;
    logic                   expire;
    logic                   done;
    logic                   winner;

    assign granted = (state == GRANT);

    // Watchdog expiry only counts when the slave stays silent; a ready in the
    // same cycle is a normal completion with real data.
    assign expire = (TIMEOUT > 0) && granted && (stall_count == COUNT_LAST)
                    && !i_bus_ready;
    assign done   = granted && (i_bus_ready || expire);

    // Contention goes to master 1 under fixed priority, otherwise to the
    // master that was not served last.
    always_comb begin
        winner = 1'b0;
        if (i_m0_request && i_m1_request) begin
            winner = (PRIORITY != 0) ? 1'b1 : ~last_served;
        end else if (i_m1_request) begin
            winner = 1'b1;
        end
    end

    // State register and latched transfer fields.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            stall_count <= '0;
            lat_rw      <= 1'b0;
            lat_address <= 32'd0;
            lat_wdata   <= 32'd0;
        end else begin
            state       <= state_next;
            owner       <= owner_next;
            last_served <= last_served_next;
            stall_count <= stall_count_next;
            lat_rw      <= lat_rw_next;
            lat_address <= lat_address_next;
            lat_wdata   <= lat_wdata_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until completion,
    // then spend one RELEASE cycle so the finished master can drop request.
    always_comb begin
        state_next       = state;
        owner_next       = owner;
        last_served_next = last_served;
        stall_count_next = stall_count;
        lat_rw_next      = lat_rw;
        lat_address_next = lat_address;
        lat_wdata_next   = lat_wdata;
        case (state)
            IDLE: begin
                if (i_m0_request || i_m1_request) begin
                    state_next       = GRANT;
                    owner_next       = winner;
                    stall_count_next = '0;
                    lat_rw_next      = winner ? i_m1_rw      : i_m0_rw;
                    lat_address_next = winner ? i_m1_address : i_m0_address;
                    lat_wdata_next   = winner ? i_m1_wdata   : i_m0_wdata;
                end
            end
            GRANT: begin
                if (done) begin
                    state_next       = RELEASE;
                    last_served_next = owner;
                end else if (TIMEOUT > 0) begin
                    stall_count_next = stall_count + COUNT_WIDTH'(1);
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus and master outputs. Everything is qualified by GRANT so a late
    // slave ready outside a transfer never reaches a master, and reset
    // forces every output low without waiting for a clock.
    always_comb begin
        o_bus_request = granted;
        o_bus_rw      = granted ? lat_rw      : 1'b0;
        o_bus_address = granted ? lat_address : 32'd0;
        o_bus_wdata   = granted ? lat_wdata   : 32'd0;
        o_timeout     = expire;
        o_m0_ready    = granted && !owner && (i_bus_ready || expire);
        o_m1_ready    = granted &&  owner && (i_bus_ready || expire);
        o_m0_rdata    = (granted && !owner && !expire) ? i_bus_rdata : 32'd0;
        o_m1_rdata    = (granted &&  owner && !expire) ? i_bus_rdata : 32'd0;
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter
// ---------------------------------------------------------------------------
// Randomized bench for cpu_bus_arbiter. Two instances run side by side:
// instance 0 uses round-robin with an 8-cycle watchdog, instance 1 uses
// fixed master-1 priority with the watchdog disabled. Each instance has its
// own random masters and slave, and its outputs are compared every cycle
// against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

    localparam int N_CYCLES    = 4000;
    localparam int RESET_CYCLE = 2000;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    // Stimulus, indexed [instance][master].
    logic [1:0]  req   [2];
    logic [1:0]  rw    [2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic        bus_ready [2];
    logic [31:0] bus_rdata [2];

    // Observed outputs, indexed [instance] or [instance][master].
    logic        m_ready [2][2];
    logic [31:0] m_rdata [2][2];
    logic        bus_req_o   [2];
    logic        bus_rw_o    [2];
    logic [31:0] bus_addr_o  [2];
    logic [31:0] bus_wdata_o [2];
    logic        timeout_o   [2];

    // Instance configuration as the model sees it.
    int prio [2] = '{0, 1};
    int tmo  [2] = '{8, 0};

    // Reference model: whether a transfer is in flight, who owns it, how many
    // silent cycles it has seen, whether a turnaround cycle is pending, who
    // was served last, and the fields captured at grant time.
    bit          busy  [2];
    int          owner [2];
    int          stall [2];
    bit          turn  [2];
    int          last  [2];
    bit          m_rw  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    bit [1:0]    served  [2];

    int check_count = 0;
    int pass_count  = 0;

    cpu_bus_arbiter #(.PRIORITY(0), .TIMEOUT(8)) dut0 (
        .i_clock      (clock),
        .i_reset      (reset_n),
        .i_m0_request (req[0][0]),
        .i_m0_rw      (rw[0][0]),
        .i_m0_address (addr[0][0]),
        .i_m0_wdata   (wdata[0][0]),
        .o_m0_ready   (m_ready[0][0]),
        .o_m0_rdata   (m_rdata[0][0]),
        .i_m1_request (req[0][1]),
        .i_m1_rw      (rw[0][1]),
        .i_m1_address (addr[0][1]),
        .i_m1_wdata   (wdata[0][1]),
        .o_m1_ready   (m_ready[0][1]),
        .o_m1_rdata   (m_rdata[0][1]),
        .o_bus_request(bus_req_o[0]),
        .o_bus_rw     (bus_rw_o[0]),
        .o_bus_address(bus_addr_o[0]),
        .o_bus_wdata  (bus_wdata_o[0]),
        .i_bus_ready  (bus_ready[0]),
        .i_bus_rdata  (bus_rdata[0]),
        .o_timeout    (timeout_o[0])
    );

    cpu_bus_arbiter #(.PRIORITY(1), .TIMEOUT(0)) dut1 (
        .i_clock      (clock),
        .i_reset      (reset_n),
        .i_m0_request (req[1][0]),
        .i_m0_rw      (rw[1][0]),
        .i_m0_address (addr[1][0]),
        .i_m0_wdata   (wdata[1][0]),
        .o_m0_ready   (m_ready[1][0]),
        .o_m0_rdata   (m_rdata[1][0]),
        .i_m1_request (req[1][1]),
        .i_m1_rw      (rw[1][1]),
        .i_m1_address (addr[1][1]),
        .i_m1_wdata   (wdata[1][1]),
        .o_m1_ready   (m_ready[1][1]),
        .o_m1_rdata   (m_rdata[1][1]),
        .o_bus_request(bus_req_o[1]),
        .o_bus_rw     (bus_rw_o[1]),
        .o_bus_address(bus_addr_o[1]),
        .o_bus_wdata  (bus_wdata_o[1]),
        .i_bus_ready  (bus_ready[1]),
        .i_bus_rdata  (bus_rdata[1]),
        .o_timeout    (timeout_o[1])
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] w1(input logic b);
        return {31'd0, b};
    endfunction

    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            busy[k]    = 1'b0;
            owner[k]   = 0;
            stall[k]   = 0;
            turn[k]    = 1'b0;
            last[k]    = 1;
            m_rw[k]    = 1'b0;
            m_addr[k]  = 32'd0;
            m_wdata[k] = 32'd0;
            served[k]  = 2'b00;
            req[k]     = 2'b00;
            rw[k]      = 2'b00;
            for (int j = 0; j < 2; j++) begin
                addr[k][j]  = 32'd0;
                wdata[k][j] = 32'd0;
            end
        end
    endtask

    // Random masters hold a request until served and drop it the cycle after,
    // sometimes changing address/data while waiting. The slave answers at
    // random, including outside any transfer.
    task automatic applyStimulus(input int k);
        for (int j = 0; j < 2; j++) begin
            if (served[k][j]) begin
                req[k][j] = 1'b0;
            end else if (!req[k][j]) begin
                if ($urandom_range(0, 99) < 30) begin
                    req[k][j]   = 1'b1;
                    rw[k][j]    = 1'($urandom_range(0, 1));
                    addr[k][j]  = $urandom;
                    wdata[k][j] = $urandom;
                end
            end else if ($urandom_range(0, 99) < 10) begin
                addr[k][j]  = $urandom;
                wdata[k][j] = $urandom;
            end
        end
        served[k]    = 2'b00;
        bus_ready[k] = ($urandom_range(0, 99) < 22);
        bus_rdata[k] = $urandom;
    endtask

    // Compare this cycle's outputs against the model, then advance the model
    // to what the arbiter does at the coming clock edge.
    task automatic modelCycle(input int k);
        bit          fire;
        bit          exp_ready;
        logic [31:0] exp_rdata;
        int          win;
        string       p;
        p = $sformatf("i%0d ", k);
        fire = busy[k] && (tmo[k] > 0) && (stall[k] == tmo[k] - 1) && !bus_ready[k];

        checkOutput({p, "bus_request"}, w1(bus_req_o[k]), w1(busy[k]));
        checkOutput({p, "timeout"}, w1(timeout_o[k]), w1(fire));
        for (int j = 0; j < 2; j++) begin
            exp_ready = busy[k] && (owner[k] == j) && (bus_ready[k] || fire);
            exp_rdata = (busy[k] && (owner[k] == j) && !fire) ? bus_rdata[k] : 32'd0;
            checkOutput($sformatf("i%0d m%0d_ready", k, j), w1(m_ready[k][j]), w1(exp_ready));
            checkOutput($sformatf("i%0d m%0d_rdata", k, j), m_rdata[k][j], exp_rdata);
            served[k][j] = exp_ready;
        end
        if (busy[k]) begin
            checkOutput({p, "bus_rw"}, w1(bus_rw_o[k]), w1(m_rw[k]));
            checkOutput({p, "bus_address"}, bus_addr_o[k], m_addr[k]);
            checkOutput({p, "bus_wdata"}, bus_wdata_o[k], m_wdata[k]);
        end

        if (busy[k]) begin
            if (bus_ready[k] || fire) begin
                last[k] = owner[k];
                busy[k] = 1'b0;
                turn[k] = 1'b1;
            end else begin
                stall[k]++;
            end
        end else if (turn[k]) begin
            turn[k] = 1'b0;
        end else if (req[k] != 2'b00) begin
            if (req[k] == 2'b11) win = (prio[k] != 0) ? 1 : 1 - last[k];
            else win = req[k][1] ? 1 : 0;
            busy[k]    = 1'b1;
            owner[k]   = win;
            stall[k]   = 0;
            m_rw[k]    = rw[k][win];
            m_addr[k]  = addr[k][win];
            m_wdata[k] = wdata[k][win];
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s i%0d bus_request", tag, k), w1(bus_req_o[k]), 32'd0);
            checkOutput($sformatf("%s i%0d bus_rw", tag, k), w1(bus_rw_o[k]), 32'd0);
            checkOutput($sformatf("%s i%0d bus_address", tag, k), bus_addr_o[k], 32'd0);
            checkOutput($sformatf("%s i%0d bus_wdata", tag, k), bus_wdata_o[k], 32'd0);
            checkOutput($sformatf("%s i%0d timeout", tag, k), w1(timeout_o[k]), 32'd0);
            for (int j = 0; j < 2; j++) begin
                checkOutput($sformatf("%s i%0d m%0d_ready", tag, k, j), w1(m_ready[k][j]), 32'd0);
                checkOutput($sformatf("%s i%0d m%0d_rdata", tag, k, j), m_rdata[k][j], 32'd0);
            end
        end
    endtask

    task automatic normalCycle();
        @(negedge clock);
        applyStimulus(0);
        applyStimulus(1);
        #1;
        modelCycle(0);
        modelCycle(1);
    endtask

    // Run until instance 0 is granted, then pull reset between clock edges
    // and confirm the bus drops immediately with the slave still answering.
    task automatic midReset();
        int guard;
        guard = 0;
        while (!busy[0] && guard < 200) begin
            normalCycle();
            guard++;
        end
        if (!busy[0]) checkOutput("reset_search expired", 32'd0, 32'd1);
        @(posedge clock);
        #2;
        checkOutput("pre_reset i0 bus_request", w1(bus_req_o[0]), 32'd1);
        bus_ready[0] = 1'b1;
        bus_ready[1] = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checkAllZero("mid_reset");
        resetModel();
        @(negedge clock);
        checkAllZero("held_reset");
        reset_n      = 1'b1;
        bus_ready[0] = 1'b0;
        bus_ready[1] = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        resetModel();
        bus_ready[0] = 1'b1;
        bus_ready[1] = 1'b1;
        bus_rdata[0] = 32'hDEADBEEF;
        bus_rdata[1] = 32'h12345678;
        req[0] = 2'b11;
        req[1] = 2'b11;
        #3;
        checkAllZero("reset");
        repeat (2) @(posedge clock);
        #1;
        checkAllZero("reset_clocked");
        resetModel();
        bus_ready[0] = 1'b0;
        bus_ready[1] = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        for (int c = 0; c < N_CYCLES; c++) begin
            if (c == RESET_CYCLE) midReset();
            else normalCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
